// File: rtl/video_stream_packer_24bit.sv
// video_stream_packer_24bit: raster-to-stream packer with frame measurement and FWFT pixel FIFO
module video_stream_packer_24bit #(
    parameter logic [15:0] DEF_XRES = 16'd640,
    parameter logic [15:0] DEF_YRES = 16'd480,
    parameter int          FIFO_AW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vin_vs,
    input  logic            vin_de,
    input  logic [2:0][7:0] vin_dat,
    output logic            frame_sync_n,
    input  logic            vout_ready,
    output logic [2:0][7:0] vout_dat,
    output logic            vout_valid,
    output logic [15:0]     vout_xres,
    output logic [15:0]     vout_yres,
    output logic            ovf,
    output logic            line_err
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_rst_sync;
    logic                 w_rst;
    logic                 r_vs, r_de;
    logic [2:0][7:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wp, r_rp;
    logic [FIFO_AW:0]     r_cnt;
    logic [15:0]          r_run, r_xm, r_ym;
    logic                 r_first_done;
    logic                 w_vs_edge, w_active, w_full, w_wr, w_drop, w_rd, w_de_rise, w_de_fall;

    assign w_rst      = r_rst_sync[1];
    assign vout_valid = r_cnt != '0;
    assign vout_dat   = vout_valid ? r_mem[r_rp] : '0;

    // assert immediately with rst, release two clean edges later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_sync <= 2'b11;
        else     r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    // next state and per-cycle strobes; the vs-edge cycle never writes or measures
    always_comb begin
        w_vs_edge   = vin_vs & ~r_vs;
        w_state_nxt = w_vs_edge ? S_ACTIVE : r_state;
        w_active    = (r_state == S_ACTIVE) & ~w_vs_edge;
        w_full      = r_cnt[FIFO_AW];
        w_wr        = w_active & vin_de & ~w_full;
        w_drop      = w_active & vin_de & w_full;
        w_rd        = vout_valid & vout_ready;
        w_de_rise   = w_active & vin_de & ~r_de;
        w_de_fall   = w_active & ~vin_de & r_de;
    end

    // state register
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // previous-cycle samples of vs and de for edge detection
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_vs <= 1'b0;
            r_de <= 1'b0;
        end else begin
            r_vs <= vin_vs;
            r_de <= vin_de;
        end
    end

    // frame-start pulse and publication of the previous frame's size
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            frame_sync_n <= 1'b1;
            vout_xres    <= DEF_XRES;
            vout_yres    <= DEF_YRES;
        end else begin
            frame_sync_n <= ~w_vs_edge;
            if (w_vs_edge && r_state == S_ACTIVE && r_ym != '0) begin
                vout_xres <= r_xm;
                vout_yres <= r_ym;
            end
        end
    end

    // FIFO pointers and occupancy; a vs edge flushes, a full write is dropped even if a read frees a slot
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            ovf   <= 1'b0;
        end else if (w_vs_edge) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_rd);
            if (w_drop) ovf <= 1'b1;
        end
    end

    // pixel storage; head word is read asynchronously for fall-through output
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= vin_dat;
    end

    // line length / line count measurement with saturation and sticky line-length check
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_run        <= '0;
            r_xm         <= '0;
            r_ym         <= '0;
            r_first_done <= 1'b0;
            line_err     <= 1'b0;
        end else if (w_vs_edge) begin
            r_run        <= '0;
            r_xm         <= '0;
            r_ym         <= '0;
            r_first_done <= 1'b0;
        end else if (w_active) begin
            if (vin_de) r_run <= r_de ? r_run + {15'd0, r_run != 16'hFFFF} : 16'd1;
            if (w_de_rise && r_ym != 16'hFFFF) r_ym <= r_ym + 16'd1;
            if (w_de_fall) begin
                if (!r_first_done) begin
                    r_xm         <= r_run;
                    r_first_done <= 1'b1;
                end else if (r_run != r_xm) begin
                    line_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_stream_packer_24bit.sv
// tb_video_stream_packer_24bit: directed frames with random data/ready against a queue-based model
module tb_video_stream_packer_24bit;
    logic            clk = 1'b0;
    logic            rst, vin_vs, vin_de, vout_ready;
    logic [2:0][7:0] vin_dat;
    logic            frame_sync_n, vout_valid, ovf, line_err;
    logic [2:0][7:0] vout_dat;
    logic [15:0]     vout_xres, vout_yres;

    int n_checks = 0;
    int n_err    = 0;

    logic [23:0] q[$];
    int          runs[$];
    bit          m_active, m_ovf, m_lerr, m_fs_n, m_vs_prev, m_de_prev;
    logic [15:0] m_xres, m_yres;
    int          m_hold, m_cur, m_lines;

    video_stream_packer_24bit dut (
        .clk(clk), .rst(rst), .vin_vs(vin_vs), .vin_de(vin_de), .vin_dat(vin_dat),
        .frame_sync_n(frame_sync_n), .vout_ready(vout_ready), .vout_dat(vout_dat),
        .vout_valid(vout_valid), .vout_xres(vout_xres), .vout_yres(vout_yres),
        .ovf(ovf), .line_err(line_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        runs.delete();
        m_active  = 0;
        m_ovf     = 0;
        m_lerr    = 0;
        m_fs_n    = 1;
        m_vs_prev = 0;
        m_de_prev = 0;
        m_xres    = 16'd640;
        m_yres    = 16'd480;
        m_cur     = 0;
        m_lines   = 0;
    endtask

    // one clock edge of the reference: frame bookkeeping in terms of run lengths, FIFO as a queue
    task automatic model_edge();
        bit rise, pop, full;
        if (rst || m_hold > 0) begin
            model_reset();
            if (rst) m_hold = 2;
            else     m_hold--;
            return;
        end
        rise      = vin_vs && !m_vs_prev;
        m_vs_prev = vin_vs;
        m_fs_n    = !rise;
        if (rise) begin
            if (m_active && m_lines > 0) begin
                m_xres = 16'((runs.size() > 0) ? runs[0] : m_cur);
                m_yres = 16'(m_lines);
            end
            q.delete();
            runs.delete();
            m_cur    = 0;
            m_lines  = 0;
            m_active = 1;
        end else begin
            pop  = q.size() > 0 && vout_ready;
            full = q.size() == 16;
            if (m_active && vin_de) begin
                if (full) m_ovf = 1;
                if (!m_de_prev) begin
                    m_lines++;
                    m_cur = 0;
                end
                m_cur++;
            end
            if (m_active && !vin_de && m_de_prev) begin
                if (runs.size() > 0 && m_cur != runs[0]) m_lerr = 1;
                runs.push_back(m_cur);
            end
            if (pop) void'(q.pop_front());
            if (m_active && vin_de && !full) q.push_back(vin_dat);
        end
        m_de_prev = vin_de;
    endtask

    function automatic bit rdy(int mode);
        return (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    endfunction

    task automatic step(bit vs, bit de, bit r);
        vin_vs     = vs;
        vin_de     = de;
        vin_dat    = de ? 24'($urandom) : 24'h0;
        vout_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("frame_sync_n", frame_sync_n, m_fs_n);
        chk("vout_valid", vout_valid, q.size() > 0);
        if (q.size() > 0) chk("vout_dat", vout_dat, q[0]);
        chk("vout_xres", vout_xres, m_xres);
        chk("vout_yres", vout_yres, m_yres);
        chk("ovf", ovf, m_ovf);
        chk("line_err", line_err, m_lerr);
    endtask

    task automatic idle(int n, int mode);
        for (int i = 0; i < n; i++) step(0, 0, rdy(mode));
    endtask

    task automatic line(int n, int gap, int mode);
        for (int i = 0; i < n; i++) step(0, 1, rdy(mode));
        idle(gap, mode);
    endtask

    task automatic vs_pulse(int mode);
        step(1, 0, rdy(mode));
        step(1, 0, rdy(mode));
        step(0, 0, rdy(mode));
    endtask

    initial begin
        rst        = 1;
        vin_vs     = 0;
        vin_de     = 0;
        vin_dat    = '0;
        vout_ready = 0;
        model_reset();
        m_hold = 2;
        idle(3, 0);
        chk("rst_fs_n", frame_sync_n, 1);
        chk("rst_valid", vout_valid, 0);
        chk("rst_dat", vout_dat, 0);
        chk("rst_xres", vout_xres, 640);
        chk("rst_yres", vout_yres, 480);
        rst = 0;
        idle(4, 1);
        // IDLE ignores de
        line(4, 2, 1);

        // first frame: 4 lines of 6 px, always ready
        vs_pulse(1);
        for (int l = 0; l < 4; l++) line(6, 3, 1);
        chk("f1_xres", vout_xres, 640);
        chk("f1_yres", vout_yres, 480);
        chk("f1_ovf", ovf, 0);

        // second vs publishes 6x4 during the sync-low cycle
        step(1, 0, 1);
        chk("f2_sync_low", frame_sync_n, 0);
        chk("f2_xres", vout_xres, 6);
        chk("f2_yres", vout_yres, 4);
        step(1, 0, 1);
        step(0, 0, 1);
        chk("f2_sync_high", frame_sync_n, 1);

        // 20 px while stalled: 16 kept, 4 dropped, then drain
        line(20, 4, 0);
        chk("ovf_set", ovf, 1);
        chk("full_valid", vout_valid, 1);
        idle(20, 1);
        chk("drained", vout_valid, 0);

        // lines of 6, 6, 5 with random back-pressure
        vs_pulse(2);
        chk("f3_xres", vout_xres, 20);
        chk("f3_yres", vout_yres, 1);
        line(6, 2, 2);
        line(6, 2, 2);
        chk("lerr_clear", line_err, 0);
        line(5, 3, 2);
        chk("lerr_set", line_err, 1);
        idle(20, 1);

        step(1, 0, 1);
        chk("f4_xres", vout_xres, 6);
        chk("f4_yres", vout_yres, 3);
        step(1, 0, 1);
        step(0, 0, 1);

        // vs edge with 5 px buffered: flushed, never delivered
        line(5, 2, 0);
        chk("five_buffered", vout_valid, 1);
        step(1, 0, 0);
        chk("flush_sync", frame_sync_n, 0);
        chk("flush_valid", vout_valid, 0);
        step(1, 0, 1);
        idle(5, 1);
        chk("flush_empty", vout_valid, 0);

        // async reset mid-line with 3 px buffered
        vs_pulse(1);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        #2 rst = 1;
        #1;
        model_reset();
        m_hold = 2;
        chk("arst_valid", vout_valid, 0);
        chk("arst_dat", vout_dat, 0);
        chk("arst_xres", vout_xres, 640);
        chk("arst_yres", vout_yres, 480);
        chk("arst_fs_n", frame_sync_n, 1);
        chk("arst_lerr", line_err, 0);
        idle(2, 1);
        rst = 0;
        idle(4, 1);
        vs_pulse(1);
        idle(5, 1);
        chk("no_stale", vout_valid, 0);
        chk("first_again_x", vout_xres, 640);

        // randomised frame, then publish its size
        for (int l = 0; l < 5; l++) line(7, 2, 2);
        vs_pulse(2);
        chk("f5_xres", vout_xres, 7);
        chk("f5_yres", vout_yres, 5);
        idle(30, 2);
        idle(20, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/video_stream_packer_24bit.md
VIDEO_STREAM_PACKER_24BIT -- requirements
Module: video_stream_packer_24bit

Interface
REQ-001 The block SHALL have parameter DEF_XRES, default 16'd640, horizontal resolution reported before the first measured frame.
REQ-002 The block SHALL have parameter DEF_YRES, default 16'd480, vertical resolution reported before the first measured frame.
REQ-003 The block SHALL have parameter FIFO_AW, default 4, FIFO address width; depth = 2**FIFO_AW entries of 24 bits.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port vin_vs, input, 1 bit, raster vertical sync, active high.
REQ-007 The block SHALL have port vin_de, input, 1 bit, raster data enable.
REQ-008 The block SHALL have port vin_dat, input, [2:0][7:0], raster pixel, byte 0 = B.
REQ-009 The block SHALL have port frame_sync_n, output, 1 bit, frame-start pulse, active low.
REQ-010 The block SHALL have port vout_ready, input, 1 bit, downstream flow control.
REQ-011 The block SHALL have port vout_dat, output, [2:0][7:0], stream pixel.
REQ-012 The block SHALL have port vout_valid, output, 1 bit, stream pixel valid.
REQ-013 The block SHALL have port vout_xres, output, 16 bits, frame width in pixels.
REQ-014 The block SHALL have port vout_yres, output, 16 bits, frame height in lines.
REQ-015 The block SHALL have port ovf, output, 1 bit, sticky FIFO overflow flag.
REQ-016 The block SHALL have port line_err, output, 1 bit, sticky line-length mismatch flag.

Function
REQ-017 The block SHALL implement states IDLE and ACTIVE; in IDLE, vin_de is ignored and nothing is written.
REQ-018 A vin_vs rising edge is a registered 0->1 sample of vin_vs; on it, from either state, the block SHALL enter ACTIVE.
REQ-019 On a vs edge, frame_sync_n SHALL be driven low for exactly 1 cycle, starting the cycle after the edge is detected.
REQ-020 In the same cycle, vout_xres/vout_yres SHALL load the previous frame's measurement; if the previous frame is absent or had zero lines, they SHALL keep their current values.
REQ-021 In the same cycle, the FIFO SHALL be flushed (pointers and count cleared) and vout_valid SHALL be 0.
REQ-022 A vin_de pixel coincident with the vs-edge detection cycle SHALL be discarded.
REQ-023 Measurement: xres_m = number of vin_de cycles in the first de run of the frame; yres_m = number of de rising edges in the frame; both are 16-bit and saturate at 16'hFFFF.
REQ-024 If any later de run length differs from xres_m, line_err SHALL be set; it is sticky until reset.
REQ-025 In ACTIVE, each vin_de=1 cycle with the FIFO not full (evaluated at cycle start) SHALL write vin_dat.
REQ-026 A vin_de=1 cycle with the FIFO full SHALL drop the pixel and set ovf, even if a read occurs in the same cycle; ovf is sticky until reset.
REQ-027 A read occurs when vout_valid=1 and vout_ready=1; the next FIFO word or empty status SHALL be presented the following cycle.
REQ-028 vout_valid SHALL equal registered FIFO-not-empty, i.e. first-word-fall-through output.
REQ-029 Minimum latency is 1 cycle: a pixel written at cycle N appears on vout_dat with vout_valid=1 at N+1.
REQ-030 Once vout_valid=1, vout_dat SHALL hold stable until accepted or until a flush.
REQ-031 Simultaneous write and read on a non-full FIFO SHALL leave the count unchanged.
REQ-032 The pointers SHALL wrap modulo 2**FIFO_AW.
REQ-033 Pixel order out SHALL equal write order; no pixel is duplicated.

Reset
REQ-034 When rst=1, the block SHALL enter state IDLE immediately (asynchronously).
REQ-035 When rst=1, frame_sync_n SHALL be 1, and vout_valid, ovf and line_err SHALL be 0.
REQ-036 When rst=1, vout_dat SHALL be 24'h0, vout_xres SHALL be DEF_XRES and vout_yres SHALL be DEF_YRES.
REQ-037 When rst=1, the FIFO SHALL be emptied and the measurement counters cleared.
REQ-038 A reset asserted mid-frame SHALL discard all buffered pixels, and the next frame SHALL be handled as the first frame.
REQ-039 Release of rst SHALL be synchronised internally so that the first active edge is clean.

Verification
REQ-040 Reset, then vs pulse, then 4 lines x 6 px with vout_ready=1 -> one frame_sync_n low pulse; xres/yres stay 640/480; 24 pixels out in order at latency 1; ovf=0.
REQ-041 Second vs pulse after that frame -> at the frame_sync_n low cycle, vout_xres=6 and vout_yres=4.
REQ-042 vout_ready=0 while 20 pixels arrive with FIFO_AW=4 -> first 16 are stored, 4 are dropped, ovf=1; releasing ready yields exactly the first 16 in order.
REQ-043 Lines of 6, 6 and 5 px -> line_err=1 after the third line ends; next-frame vout_xres=6 and vout_yres=3.
REQ-044 vs edge while the FIFO holds 5 pixels -> vout_valid=0 during the frame_sync_n low cycle; none of the 5 pixels is ever output.
REQ-045 rst pulsed mid-line with 3 pixels buffered -> vout_valid=0 immediately; xres/yres=640/480; no stale pixel appears after the next vs.
